// File: rtl/cv32e40x_rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter and its
// pending-write scoreboard.
package cv32e40x_rf_write_arbiter_pkg;

   typedef logic [4:0]  rf_addr_t;
   typedef logic [31:0] rf_data_t;

   typedef enum logic {
      RF_ARB_NORMAL = 1'b0,
      RF_ARB_FORCE  = 1'b1
   } rf_arb_state_e;

   localparam int unsigned RF_ARB_STARVE_LIMIT_DEFAULT = 4;
   // Wide enough for the largest legal starvation limit (15).
   localparam int unsigned RF_ARB_CNT_W = 4;

endpackage

// File: rtl/cv32e40x_rf_scoreboard.sv
// Pending-write scoreboard for offloaded instructions: one bit per GPR,
// x0 never tracked, with a combinational hazard lookup per ID read port.
module cv32e40x_rf_scoreboard
   import cv32e40x_rf_write_arbiter_pkg::*;
#(
   parameter int unsigned NUM_READ_PORTS = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_set_en,
   input  rf_addr_t                       i_set_addr,
   input  logic                           i_clr_en,
   input  rf_addr_t                       i_clr_addr,
   input  rf_addr_t [NUM_READ_PORTS-1:0]  i_raddr,
   output logic [NUM_READ_PORTS-1:0]      o_hazard
);

   logic [31:1] r_sb;
   logic [31:1] w_sb_next;
   logic [31:0] w_sb_full;

   // Set is applied after clear so a same-cycle issue to the same rd survives.
   always_comb begin
      w_sb_next = r_sb;
      for (int k = 1; k < 32; k++) begin
         if (i_clr_en && (i_clr_addr == rf_addr_t'(k))) begin
            w_sb_next[k] = 1'b0;
         end
         if (i_set_en && (i_set_addr == rf_addr_t'(k))) begin
            w_sb_next[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sb <= '0;
      end else begin
         r_sb <= w_sb_next;
      end
   end

   assign w_sb_full = {r_sb, 1'b0};

   always_comb begin
      o_hazard = '0;
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
         o_hazard[p] = w_sb_full[i_raddr[p]];
      end
   end

endmodule

// File: rtl/cv32e40x_rf_write_arbiter.sv
// Shares the register-file write port between WB and the X result bus, with a
// starvation guard that stalls WB so a blocked X result can drain.
module cv32e40x_rf_write_arbiter
   import cv32e40x_rf_write_arbiter_pkg::*;
#(
   parameter int unsigned NUM_READ_PORTS = 2,
   parameter int unsigned STARVE_LIMIT   = RF_ARB_STARVE_LIMIT_DEFAULT
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wb_we_i,
   input  rf_addr_t                       wb_waddr_i,
   input  rf_data_t                       wb_wdata_i,
   output logic                           wb_stall_o,
   input  logic                           x_valid_i,
   output logic                           x_ready_o,
   input  rf_addr_t                       x_waddr_i,
   input  rf_data_t                       x_wdata_i,
   input  logic                           iss_valid_i,
   input  rf_addr_t                       iss_rd_i,
   input  rf_addr_t [NUM_READ_PORTS-1:0]  raddr_i,
   output logic [NUM_READ_PORTS-1:0]      rd_hazard_o,
   output logic                           rf_we_o,
   output rf_addr_t                       rf_waddr_o,
   output rf_data_t                       rf_wdata_o
);

   localparam logic [RF_ARB_CNT_W-1:0] LP_CNT_LAST = RF_ARB_CNT_W'(STARVE_LIMIT - 1);

   rf_arb_state_e             r_state;
   rf_arb_state_e             w_state_next;
   logic [RF_ARB_CNT_W-1:0]   r_cnt;
   logic [RF_ARB_CNT_W-1:0]   w_cnt_next;
   logic                      r_wb_stall;

   logic                      w_x_ready;
   logic                      w_x_hs;
   logic                      w_x_lost;
   logic                      w_sel_req;
   rf_addr_t                  w_sel_addr;
   rf_data_t                  w_sel_data;
   logic [NUM_READ_PORTS-1:0] w_hazard;

   // WB has no backpressure, so it always wins; X only goes when WB is idle.
   assign w_x_ready = x_valid_i & ~wb_we_i;
   assign w_x_hs    = w_x_ready;
   assign w_x_lost  = x_valid_i & ~w_x_ready;

   assign w_sel_req  = wb_we_i | x_valid_i;
   assign w_sel_addr = wb_we_i ? wb_waddr_i : x_waddr_i;
   assign w_sel_data = wb_we_i ? wb_wdata_i : x_wdata_i;

   assign rf_we_o     = w_sel_req & (w_sel_addr != '0) & ~rst;
   assign rf_waddr_o  = w_sel_addr;
   assign rf_wdata_o  = w_sel_data;
   assign x_ready_o   = w_x_ready & ~rst;
   assign wb_stall_o  = r_wb_stall;
   assign rd_hazard_o = w_hazard & {NUM_READ_PORTS{~rst}};

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = '0;
      unique case (r_state)
         RF_ARB_NORMAL: begin
            if (w_x_lost) begin
               if (r_cnt == LP_CNT_LAST) begin
                  w_state_next = RF_ARB_FORCE;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
         end
         RF_ARB_FORCE: begin
            // A dropped valid without handshake is a protocol violation; recover anyway.
            if (w_x_hs || !x_valid_i) begin
               w_state_next = RF_ARB_NORMAL;
            end
         end
         default: w_state_next = RF_ARB_NORMAL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= RF_ARB_NORMAL;
         r_cnt      <= '0;
         r_wb_stall <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_wb_stall <= (w_state_next == RF_ARB_FORCE);
      end
   end

   cv32e40x_rf_scoreboard #(
      .NUM_READ_PORTS (NUM_READ_PORTS)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .i_set_en   (iss_valid_i),
      .i_set_addr (iss_rd_i),
      .i_clr_en   (w_x_hs),
      .i_clr_addr (x_waddr_i),
      .i_raddr    (raddr_i),
      .o_hazard   (w_hazard)
   );

   // The X source must hold its result stable until it is accepted.
   property p_x_stable;
      @(posedge clk) disable iff (rst)
         (x_valid_i && !w_x_ready) |=>
            (x_valid_i && $stable(x_waddr_i) && $stable(x_wdata_i));
   endproperty
   a_x_stable: assert property (p_x_stable);

endmodule
